disp_capture: RTL and testbench
===============================

DISP_CAPTURE -- requirements
Module: disp_capture

Interface
REQ-001 SHALL have parameter BPC, default 5, meaning bits per colour channel of the captured display stream.
REQ-002 SHALL have parameter CORDW, default 16, meaning signed coordinate width in bits.
REQ-003 SHALL have parameters CAP_X0 and CAP_Y0, default 0 and 0, meaning the top-left corner of the capture window in display pixels.
REQ-004 SHALL have parameters CAP_W and CAP_H, default 672 and 384, meaning the capture window size; each SHALL be >=1.
REQ-005 SHALL have parameter FIFO_DEPTH, default 16, meaning output FIFO entries; it SHALL be a power of two and >=2.
REQ-006 SHALL have port clk_sys, input, 1, the single clock; all logic SHALL be on its rising edge.
REQ-007 SHALL have port rst_sys_n, input, 1, reset; reset is synchronous and active-low.
REQ-008 SHALL have ports disp_x and disp_y, input, CORDW signed, the current display position.
REQ-009 SHALL have ports disp_de and disp_frame, input, 1 each: data enable, and a one-cycle frame-start strobe.
REQ-010 SHALL have ports disp_r, disp_g and disp_b, input, BPC each, the pixel colour.
REQ-011 SHALL have port arm, input, 1, a request to capture the next full frame window.
REQ-012 SHALL have port cap_data, output, 3*BPC, the pixel packed as {r,g,b}.
REQ-013 SHALL have ports cap_valid (output, 1), cap_ready (input, 1) and cap_last (output, 1): a valid/ready stream, with cap_last marking the window's final pixel.
REQ-014 SHALL have ports busy, done and overflow, output, 1 each: busy means a capture is in progress; done is a one-cycle completion pulse; overflow is a sticky pixel-dropped flag.

Function
REQ-015 SHALL implement FSM states IDLE, ARMED, CAPTURE and DRAIN.
REQ-016 IDLE: arm=1 SHALL transition to ARMED next cycle and clear overflow; arm in any other state SHALL be ignored.
REQ-017 ARMED: disp_frame=1 SHALL transition to CAPTURE next cycle; pixels before that transition SHALL NOT be captured.
REQ-018 Pixels in the window: a pixel is in the window iff disp_de=1, CAP_X0<=disp_x<CAP_X0+CAP_W and CAP_Y0<=disp_y<CAP_Y0+CAP_H.
REQ-019 Pixel registration: every in-window pixel sampled in CAPTURE SHALL be registered one stage, then pushed to the FIFO with its last bit.
REQ-020 cap_last: the last bit SHALL be 1 only for x=CAP_X0+CAP_W-1, y=CAP_Y0+CAP_H-1.
REQ-021 Window coordinate comparisons SHALL be signed, at CORDW+1 bits to avoid overflow of CAP_X0+CAP_W.
REQ-022 Sampling the last pixel SHALL move the FSM CAPTURE->DRAIN, even if that pixel is dropped.
REQ-023 A disp_frame strobe in CAPTURE SHALL be ignored.
REQ-024 DRAIN: when the FIFO is empty and no push is pending, the FSM SHALL go to IDLE, with done=1 for exactly that transition cycle.
REQ-025 busy SHALL be 1 in ARMED, CAPTURE and DRAIN, and 0 in IDLE.
REQ-026 Latency: a pixel sampled at cycle n SHALL appear on cap_data with cap_valid=1 no earlier than n+2, when the FIFO was empty.
REQ-027 The FIFO SHALL be show-ahead: cap_valid=1 whenever non-empty, and cap_data/cap_last SHALL hold the oldest entry.
REQ-028 A pop SHALL occur iff cap_valid & cap_ready.
REQ-029 cap_data and cap_last SHALL be stable while cap_valid=1 and cap_ready=0.
REQ-030 FIFO full: a push SHALL be dropped and overflow set to 1, unless a pop occurs in the same cycle; then the push SHALL be accepted and the count unchanged.
REQ-031 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave the count unchanged.
REQ-032 A push into an empty FIFO SHALL NOT bypass the storage stage.
REQ-033 overflow SHALL stay 1 until reset or the next accepted arm.

Reset
REQ-034 rst_sys_n=0 at a clock edge SHALL force: state IDLE, FIFO empty, pipeline stage cleared, cap_valid=0, cap_last=0, cap_data=0, busy=0, done=0, overflow=0.
REQ-035 Reset mid-capture SHALL discard all FIFO contents, with no done pulse.
REQ-036 After reset is released, the block SHALL need a new arm before it captures.

Verification
REQ-037 Window (10,5) size 4x2, depth 16, cap_ready=1, arm then frame -> 8 words in raster order; cap_last only on (13,6); done one cycle after the last pop; overflow=0.
REQ-038 Same window, depth 4, cap_ready=0 until DRAIN -> 4 words accepted (pixels (10,5)..(13,5)); overflow=1; the drained 4th word has cap_last=0; done after the 4 pops.
REQ-039 arm during CAPTURE, and disp_frame again in CAPTURE -> no restart; exactly 8 words, a single done.
REQ-040 Pixels with disp_de=0 inside the window, or with x=9 or x=14 -> not captured.
REQ-041 Pixel count with full FIFO plus pop each cycle -> no drops; overflow=0.
REQ-042 rst_sys_n low for 1 cycle after 3 pushes -> cap_valid=0 next cycle; the following frame without arm -> no words.

Source files
------------

// File: rtl/disp_capture.sv
// Captures one rectangular window of a raster display stream and emits it as a valid/ready
// pixel stream through a small show-ahead FIFO, one frame per arm request.
module disp_capture #(
    parameter int BPC        = 5,
    parameter int CORDW      = 16,
    parameter int CAP_X0     = 0,
    parameter int CAP_Y0     = 0,
    parameter int CAP_W      = 672,
    parameter int CAP_H      = 384,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                    clk_sys,
    input  logic                    rst_sys_n,
    input  logic signed [CORDW-1:0] disp_x,
    input  logic signed [CORDW-1:0] disp_y,
    input  logic                    disp_de,
    input  logic                    disp_frame,
    input  logic [BPC-1:0]          disp_r,
    input  logic [BPC-1:0]          disp_g,
    input  logic [BPC-1:0]          disp_b,
    input  logic                    arm,
    output logic [3*BPC-1:0]        cap_data,
    output logic                    cap_valid,
    input  logic                    cap_ready,
    output logic                    cap_last,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow
);

    // state   | meaning
    // IDLE    | waiting for arm
    // ARMED   | waiting for the next frame-start strobe
    // CAPTURE | sampling in-window pixels into the pipeline/FIFO
    // DRAIN   | window finished, emptying pipeline and FIFO
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_DRAIN   = 2'd3;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = 3*BPC + 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    // One extra bit keeps CAP_X0+CAP_W from wrapping at the top of the coordinate range.
    localparam logic signed [CORDW:0] X_LO   = (CORDW+1)'(CAP_X0);
    localparam logic signed [CORDW:0] X_HI   = (CORDW+1)'(CAP_X0 + CAP_W);
    localparam logic signed [CORDW:0] X_LAST = (CORDW+1)'(CAP_X0 + CAP_W - 1);
    localparam logic signed [CORDW:0] Y_LO   = (CORDW+1)'(CAP_Y0);
    localparam logic signed [CORDW:0] Y_HI   = (CORDW+1)'(CAP_Y0 + CAP_H);
    localparam logic signed [CORDW:0] Y_LAST = (CORDW+1)'(CAP_Y0 + CAP_H - 1);

    logic [1:0] state, state_nxt;

    logic signed [CORDW:0] pos_x, pos_y;
    logic in_win, at_last, sample;

    logic           pipe_valid;
    logic [DW-1:0]  pipe_word;

    logic [DW-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count;
    logic [DW-1:0]  rd_word;
    logic           full, pop, push_ok, drained;

    assign pos_x = {disp_x[CORDW-1], disp_x};
    assign pos_y = {disp_y[CORDW-1], disp_y};

    assign in_win  = disp_de && (pos_x >= X_LO) && (pos_x < X_HI)
                             && (pos_y >= Y_LO) && (pos_y < Y_HI);
    assign at_last = (pos_x == X_LAST) && (pos_y == Y_LAST);
    assign sample  = (state == S_CAPTURE) && in_win;

    assign full    = (count == FULL_CNT);
    assign pop     = cap_valid && cap_ready;
    assign push_ok = pipe_valid && (!full || pop);
    assign drained = (count == '0) && !pipe_valid;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (arm) state_nxt = S_ARMED;
            S_ARMED:   if (disp_frame) state_nxt = S_CAPTURE;
            S_CAPTURE: if (sample && at_last) state_nxt = S_DRAIN;
            S_DRAIN:   if (drained) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_sys_n) begin
            state    <= S_IDLE;
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && arm) begin
                overflow <= 1'b0;
            end else if (pipe_valid && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_sys_n) begin
            pipe_valid <= 1'b0;
            pipe_word  <= '0;
        end else begin
            pipe_valid <= sample;
            if (sample) begin
                pipe_word <= {disp_r, disp_g, disp_b, at_last};
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_sys_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage has no reset; the read side is masked until an entry is valid.
    always_ff @(posedge clk_sys) begin
        if (push_ok) begin
            mem[wr_ptr] <= pipe_word;
        end
    end

    assign rd_word   = mem[rd_ptr];
    assign cap_valid = (count != '0);
    assign cap_data  = cap_valid ? rd_word[DW-1:1] : '0;
    assign cap_last  = cap_valid && rd_word[0];

    assign busy = (state != S_IDLE);
    assign done = (state == S_DRAIN) && drained;

endmodule

// File: tb/tb_disp_capture.sv
// Scoreboard bench for disp_capture: a 4x2 window at (10,5) inside a 16x8 raster,
// with a 4-entry FIFO so that back-pressure and overflow are easy to reach.
module tb_disp_capture;

    logic               clk_sys = 1'b0;
    logic               rst_sys_n;
    logic signed [15:0] disp_x, disp_y;
    logic               disp_de, disp_frame;
    logic [4:0]         disp_r, disp_g, disp_b;
    logic               arm;
    logic [14:0]        cap_data;
    logic               cap_valid, cap_ready, cap_last;
    logic               busy, done, overflow;

    int n_pass = 0;
    int n_chk  = 0;
    int cyc    = 0;
    int words  = 0;
    int done_cnt = 0;
    int last_pop_cyc = 0;
    int done_cyc = 0;
    logic [15:0] exp_q [$];
    logic [15:0] exp_word;

    always #5 clk_sys = ~clk_sys;

    disp_capture #(
        .BPC(5), .CORDW(16), .CAP_X0(10), .CAP_Y0(5),
        .CAP_W(4), .CAP_H(2), .FIFO_DEPTH(4)
    ) dut (
        .clk_sys(clk_sys), .rst_sys_n(rst_sys_n),
        .disp_x(disp_x), .disp_y(disp_y),
        .disp_de(disp_de), .disp_frame(disp_frame),
        .disp_r(disp_r), .disp_g(disp_g), .disp_b(disp_b),
        .arm(arm),
        .cap_data(cap_data), .cap_valid(cap_valid), .cap_ready(cap_ready), .cap_last(cap_last),
        .busy(busy), .done(done), .overflow(overflow)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    always @(posedge clk_sys) cyc++;

    always @(negedge clk_sys) begin
        if (cap_valid === 1'b1 && cap_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("extra_word", 32'(cap_valid), 32'd0);
            end else begin
                exp_word = exp_q.pop_front();
                check_eq("word", 32'({cap_data, cap_last}), 32'(exp_word));
            end
            words++;
            last_pop_cyc = cyc;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check_eq("arm_busy", 32'(busy), 32'd1);
        check_eq("arm_ovf_clr", 32'(overflow), 32'd0);
    endtask

    // One frame: frame strobe on a blank cycle, then 8 lines of x=-2..17 with de on x=0..15.
    task automatic run_frame(input bit cap_en_in, input int limit,
                             input int hole_x, input int hole_y, input int restrike_y,
                             input int ready_x, input int ready_y,
                             input int rst_x, input int rst_y);
        bit cap_en;
        int pushed;
        logic [14:0] seed;
        logic [4:0] r, g, b;
        cap_en = cap_en_in;
        pushed = 0;
        seed = 15'($urandom);
        disp_frame = 1'b1;
        disp_de = 1'b0;
        disp_x = -16'sd1;
        disp_y = -16'sd1;
        tick();
        for (int y = 0; y < 8; y++) begin
            for (int x = -2; x < 18; x++) begin
                disp_x = 16'(x);
                disp_y = 16'(y);
                disp_de = (x >= 0 && x < 16 && !(x == hole_x && y == hole_y)) ? 1'b1 : 1'b0;
                r = 5'(x) ^ seed[4:0];
                g = 5'(y) ^ seed[9:5];
                b = 5'(x + y) ^ seed[14:10];
                disp_r = r;
                disp_g = g;
                disp_b = b;
                disp_frame = (x == 0 && y == restrike_y) ? 1'b1 : 1'b0;
                arm = disp_frame;
                if (x == ready_x && y == ready_y) cap_ready = 1'b1;
                rst_sys_n = (x == rst_x && y == rst_y) ? 1'b0 : 1'b1;
                if (!rst_sys_n) begin
                    cap_en = 1'b0;
                    exp_q.delete();
                end
                if (cap_en && disp_de && x >= 10 && x < 14 && y >= 5 && y < 7 && pushed < limit) begin
                    exp_q.push_back({r, g, b, (x == 13 && y == 6) ? 1'b1 : 1'b0});
                    pushed++;
                end
                tick();
                if (!rst_sys_n) begin
                    check_eq("rst_valid", 32'(cap_valid), 32'd0);
                    check_eq("rst_last", 32'(cap_last), 32'd0);
                    check_eq("rst_data", 32'(cap_data), 32'd0);
                    check_eq("rst_busy", 32'(busy), 32'd0);
                    check_eq("rst_ovf", 32'(overflow), 32'd0);
                end
            end
        end
        disp_de = 1'b0;
        disp_frame = 1'b0;
        arm = 1'b0;
        rst_sys_n = 1'b1;
        disp_x = -16'sd1;
        disp_y = -16'sd1;
    endtask

    task automatic finish_capture(input string nm, input int w0, input int d0,
                                  input int exp_words, input logic exp_ovf);
        for (int i = 0; i < 300 && done_cnt == d0; i++) tick();
        repeat (4) tick();
        check_eq({nm, "_done_cnt"}, 32'(done_cnt - d0), 32'd1);
        check_eq({nm, "_words"}, 32'(words - w0), 32'(exp_words));
        check_eq({nm, "_q_left"}, 32'(exp_q.size()), 32'd0);
        check_eq({nm, "_ovf"}, 32'(overflow), 32'(exp_ovf));
        check_eq({nm, "_busy"}, 32'(busy), 32'd0);
        check_eq({nm, "_done_lat"}, 32'(done_cyc - last_pop_cyc), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        int w0, d0;
        rst_sys_n = 1'b0;
        disp_x = '0; disp_y = '0; disp_de = 1'b0; disp_frame = 1'b0;
        disp_r = '0; disp_g = '0; disp_b = '0;
        arm = 1'b0; cap_ready = 1'b0;
        repeat (3) tick();
        check_eq("reset_valid", 32'(cap_valid), 32'd0);
        check_eq("reset_last", 32'(cap_last), 32'd0);
        check_eq("reset_data", 32'(cap_data), 32'd0);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_done", 32'(done), 32'd0);
        check_eq("reset_ovf", 32'(overflow), 32'd0);
        rst_sys_n = 1'b1;
        tick();

        // Plain capture, always ready.
        cap_ready = 1'b1;
        w0 = words; d0 = done_cnt;
        do_arm();
        run_frame(1'b1, 100, -100, -100, -100, -100, -100, -100, -100);
        finish_capture("basic", w0, d0, 8, 1'b0);

        // Back-pressure until the window is over: only the first row fits.
        cap_ready = 1'b0;
        w0 = words; d0 = done_cnt;
        do_arm();
        run_frame(1'b1, 4, -100, -100, -100, -100, -100, -100, -100);
        check_eq("bp_ovf_set", 32'(overflow), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("bp_hold", 32'({cap_data, cap_last}), 32'(exp_q[0]));
            check_eq("bp_valid", 32'(cap_valid), 32'd1);
        end
        cap_ready = 1'b1;
        finish_capture("bp", w0, d0, 4, 1'b1);

        // Re-arm and frame strobe mid-capture must not restart anything.
        w0 = words; d0 = done_cnt;
        do_arm();
        run_frame(1'b1, 100, -100, -100, 6, -100, -100, -100, -100);
        finish_capture("restrike", w0, d0, 8, 1'b0);

        // A de hole inside the window drops just that pixel.
        w0 = words; d0 = done_cnt;
        do_arm();
        run_frame(1'b1, 100, 11, 5, -100, -100, -100, -100, -100);
        finish_capture("de_hole", w0, d0, 7, 1'b0);

        // FIFO full from row 5, ready rises so pop and push coincide while full.
        cap_ready = 1'b0;
        w0 = words; d0 = done_cnt;
        do_arm();
        run_frame(1'b1, 100, -100, -100, -100, 11, 6, -100, -100);
        finish_capture("full_pop", w0, d0, 8, 1'b0);

        // Reset mid-capture, then a frame without arm captures nothing.
        cap_ready = 1'b0;
        w0 = words; d0 = done_cnt;
        do_arm();
        run_frame(1'b1, 100, -100, -100, -100, -100, -100, 14, 5);
        repeat (4) tick();
        check_eq("rst_mid_valid", 32'(cap_valid), 32'd0);
        check_eq("rst_mid_busy", 32'(busy), 32'd0);
        cap_ready = 1'b1;
        run_frame(1'b0, 100, -100, -100, -100, -100, -100, -100, -100);
        repeat (6) tick();
        check_eq("noarm_words", 32'(words - w0), 32'd0);
        check_eq("noarm_done", 32'(done_cnt - d0), 32'd0);
        check_eq("noarm_busy", 32'(busy), 32'd0);
        check_eq("noarm_valid", 32'(cap_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
